icache_direct: RTL

Direct-mapped instruction cache between the IF stage and `mem_ctrl`. It serves fetches from on-chip tag/data arrays on a hit. On a miss it issues a word request on `mem_ctrl`'s instruction port (`icache_needed`/`icache_addr`), waits for `inst_data_enable`, refills the line and returns the word. The IF-facing handshake has one-cycle hit latency, and pending misses can be cancelled by `flush` on a redirect.

---
 rtl/icache_direct.sv | 136 +++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-line instruction cache between IF and mem_ctrl.
// Define ICACHE_EN to build the tag/data arrays; otherwise every fetch takes the miss path.
module icache_direct #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_LEN   = 32,
  parameter int INST_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  input  logic                flush,
  output logic                inst_valid,
  output logic [INST_LEN-1:0] inst,
  output logic                if_busy,
  output logic                icache_needed,
  output logic [ADDR_LEN-1:0] icache_addr,
  input  logic [INST_LEN-1:0] inst_i,
  input  logic                inst_data_enable,
  input  logic                mem_busy
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_LEN - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                state_q, state_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [INST_LEN-1:0]   inst_q, inst_d;
  logic                  needed_q, needed_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic                  fill_we;
  logic                  hit;
  logic [INST_LEN-1:0]   hit_data;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;

  assign req_idx  = if_addr[INDEX_BITS+1:2];
  assign req_tag  = if_addr[ADDR_LEN-1:INDEX_BITS+2];
  // The fill target comes from the latched miss address, not the live IF bus.
  assign fill_idx = addr_q[INDEX_BITS+1:2];
  assign fill_tag = addr_q[ADDR_LEN-1:INDEX_BITS+2];

`ifdef ICACHE_EN
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_LEN-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         valid_q <= '0;
    else if (fill_we) valid_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= inst_i;
    end
  end

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_data = data_q[req_idx];

  logic unused_ok;
  assign unused_ok = ^{mem_busy, if_addr[1:0], addr_q[1:0]};
`else
  assign hit      = 1'b0;
  assign hit_data = '0;

  logic unused_ok;
  assign unused_ok = ^{mem_busy, if_addr[1:0], addr_q[1:0], req_idx, req_tag,
                       fill_idx, fill_tag, fill_we};
`endif

  always_comb begin
    state_d      = state_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    needed_d     = needed_q;
    addr_d       = addr_q;
    fill_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req && !flush) begin
          if (hit) begin
            inst_d       = hit_data;
            inst_valid_d = 1'b1;
          end else begin
            addr_d   = {if_addr[ADDR_LEN-1:2], 2'b00};
            needed_d = 1'b1;
            state_d  = MISS;
          end
        end
      end
      MISS: begin
        if (inst_data_enable) begin
          // A redirect on the fill edge still installs the line; only the response is dropped.
          fill_we  = 1'b1;
          needed_d = 1'b0;
          state_d  = IDLE;
          if (!flush) begin
            inst_d       = inst_i;
            inst_valid_d = 1'b1;
          end
        end else if (flush) begin
          needed_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      needed_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      needed_q     <= needed_d;
      addr_q       <= addr_d;
    end
  end

  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign icache_needed = needed_q;
  assign icache_addr   = addr_q;
  assign if_busy       = (state_q == MISS);
endmodule
